// File: rtl/reflet_uart_rx_fifo_if.sv
// CPU-facing side of the UART receiver: pop/clear strobes in, FIFO head and
// status out. The CPU (or bench) holds the master end; the receiver the slave.
interface reflet_uart_rx_fifo_if #(
  parameter int depth_log2 = 3
);
  logic                  rd_en;
  logic                  clr_err;
  logic [7:0]            data_out;
  logic                  empty;
  logic                  full;
  logic [depth_log2:0]   count;
  logic                  overrun;
  logic                  frame_err;
  logic                  irq;
`ifdef REFLET_UART_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output rd_en, clr_err,
    input  data_out, empty, full, count, overrun, frame_err, irq
`ifdef REFLET_UART_RX_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  rd_en, clr_err,
    output data_out, empty, full, count, overrun, frame_err, irq
`ifdef REFLET_UART_RX_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/reflet_uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// Optional even-parity frame (8E1) when REFLET_UART_RX_PARITY_EN is defined,
// which also adds the sticky parity_err flag.
module reflet_uart_rx_fifo #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int depth_log2 = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  reflet_uart_rx_fifo_if.slave bus
);

  localparam int bit_len = clk_freq / baud_rate;
  localparam int tw      = $clog2(bit_len);
  localparam int depth   = 2 ** depth_log2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef REFLET_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [tw-1:0]       timer;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic [1:0]          sync_q;
  logic                rxs_q;
  logic                rxs;
  logic                fall;

  logic [7:0]          mem [depth];
  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic [depth_log2:0]   count;
  logic                  empty, full;

  logic stop_tick, push_req, frame_evt, do_pop, do_push, ovf_evt;

  assign rxs  = sync_q[1];
  assign fall = rxs_q & ~rxs;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all preset to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      rxs_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; blocking
      // here would collapse the synchroniser chain into a single stage.
      sync_q <= {sync_q[0], rx};
      rxs_q  <= sync_q[1];
    end
  end

`ifdef REFLET_UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err;
  logic parity_evt;
  assign parity_evt = (state == PARITY) && (timer == '0) && (rxs ^ (^shreg));
  assign push_req   = stop_tick && rxs && !par_bad;
`else
  assign push_req   = stop_tick && rxs;
`endif

  // Frame sequencer: mid-bit sampling driven by a down-counting bit timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef REFLET_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            bit_cnt <= '0;
            timer   <= tw'(bit_len / 2 - 1);
            state   <= START;
          end
        end
        START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (!rxs) begin
            timer <= tw'(bit_len - 1);
            state <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shreg   <= {rxs, shreg[7:1]};
            timer   <= tw'(bit_len - 1);
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef REFLET_UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef REFLET_UART_RX_PARITY_EN
        PARITY: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            par_bad <= rxs ^ (^shreg);
            timer   <= tw'(bit_len - 1);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (timer != '0) timer <= timer - 1'b1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state == STOP) && (timer == '0);
  assign frame_evt = stop_tick && !rxs;
  assign empty     = (count == '0);
  assign full      = (count == (depth_log2 + 1)'(depth));
  assign do_pop    = bus.rd_en && !empty;
  assign do_push   = push_req && (!full || do_pop);
  assign ovf_evt   = push_req && full && !do_pop;

  // Byte storage, written at the stop-bit sample.
  // NOTE: the array has no reset; stale contents are never visible because
  // data_out is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.overrun   <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;

      if (ovf_evt)          bus.overrun <= 1'b1;
      else if (bus.clr_err) bus.overrun <= 1'b0;

      if (frame_evt)        bus.frame_err <= 1'b1;
      else if (bus.clr_err) bus.frame_err <= 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
      if (parity_evt)       parity_err <= 1'b1;
      else if (bus.clr_err) parity_err <= 1'b0;
`endif
    end
  end

`ifdef REFLET_UART_RX_PARITY_EN
  assign bus.parity_err = parity_err;
`endif
  assign bus.data_out = empty ? 8'h00 : mem[rd_ptr];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count;
  assign bus.irq      = !empty;

endmodule

// File: doc/reflet_uart_rx_fifo.md
Name: reflet_uart_rx_fifo

Overview:
UART receive front-end with a byte FIFO. It deserialises the 8N1 serial line that an external UART driver sends to the MCU. Received bytes are buffered so the CPU, through the peripheral bus, can drain them at its own pace. It sits between the `rx` pin and the peripheral register file, replacing a single-byte receive register so back-to-back bytes at 9600 baud are not lost while the CPU is busy.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate. Bit period `BIT = clk_freq/baud_rate`, integer-truncated (104 at the defaults).
- depth_log2, 3, FIFO depth is `2**depth_log2` bytes (8 at the default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  pop strobe, one byte per cycle when high and not empty.
- clr_err  input  1  clears the sticky error flags.
- data_out  output  8  FIFO head byte (first-word fall-through).
- empty  output  1  FIFO holds 0 bytes.
- full  output  1  FIFO holds `2**depth_log2` bytes.
- count  output  depth_log2+1  number of bytes held.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- irq  output  1  equals `!empty`; feeds an ext_int line.

Behaviour:
- Reset (reset=0), asynchronous:
  - FSM goes to IDLE; FIFO pointers and count are cleared.
  - empty=1, full=0, count=0, overrun=0, frame_err=0, irq=0, data_out=8'h00.
  - Synchroniser flops are preset to 1.
- Input path: rx passes through a 2-flop synchroniser (2 cycles of latency). All decoding uses the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rxs loads the bit counter with 0, loads the timer with `BIT/2 - 1`, and moves to START.
  - START: when the timer reaches 0, sample rxs.
    - Sample 0: reload the timer with `BIT-1` and go to DATA.
    - Sample 1: glitch, return to IDLE with no flags changed.
  - DATA: each time the timer reaches 0, shift rxs into the shift register LSB-first and reload the timer with `BIT-1`. After the 8th bit, go to STOP.
  - STOP: when the timer reaches 0, sample rxs.
    - Sample 1: push the byte.
    - Sample 0: set frame_err and discard the byte.
    - Either way, return to IDLE. The next start edge is accepted on the very next cycle.
- Push timing: the byte is written in the cycle the stop bit is sampled. count, empty and data_out reflect it on the following cycle.
- Pop: if rd_en=1 and empty=0, the read pointer advances and data_out shows the next entry one cycle later. If rd_en=1 and empty=1, the pop is ignored and no flag changes.
- Push while full:
  - Without a pop in the same cycle, the byte is dropped, overrun is set, and the FIFO is unchanged.
  - If a pop occurs in the same cycle, both the push and the pop succeed, count stays at full, and overrun is not set.
- Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- Pointers are depth_log2 bits wide and wrap modulo depth. count is maintained separately, and full is `count == 2**depth_log2`.
- clr_err=1 clears overrun and frame_err on the next edge. A new error event in the same cycle wins, so the flag stays set.
- A line held low (break) produces frame_err once. The FSM then waits in IDLE for rxs to go high before it accepts a new falling edge.

Optional Feature:
- Macro: REFLET_UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, expecting even parity over the 8 data bits.
  - An extra output, parity_err (sticky, cleared by clr_err, reset 0), is added.
  - A parity mismatch sets parity_err and discards the byte, but the FSM still checks the stop bit.
- When not defined: the frame is 8N1, and neither the PARITY state nor the parity_err port exists.

Test Plan:
- Reset low, then high with rx=1 and no traffic → empty=1, count=0, irq=0, and both flags are 0 for 1000 cycles.
- Send 8'hA5 at 9600 baud, clk_freq 1e6 → about 10×104 cycles later count=1, data_out=8'hA5, irq=1. A one-cycle rd_en then gives empty=1.
- Send 9 bytes 8'h01..8'h09 back-to-back with no reads → full=1 and count=8 after byte 8. After byte 9, overrun=1. Draining returns 01..08 in order; clr_err then clears overrun.
- Send a frame with the stop bit forced low (data 8'h3C) → frame_err=1 and count is unchanged. A following valid 8'h7E is received correctly.
- Apply a 20-cycle low glitch on rx → no byte, no flags, FSM back in IDLE. Also assert reset mid-frame (during DATA) → all outputs return to their reset values, and the next full frame 8'h55 is received.
- With REFLET_UART_RX_PARITY_EN: send 8'h03 with parity bit 1 → parity_err=1 and no push. Send 8'h03 with parity bit 0 → pushed.
